pwmin_capture: RTL and testbench

PWM input measurement block, the receive-side counterpart of the pwm/dir output generator. It samples an external PWM line plus a direction line and measures high time and period in clk cycles. It outputs a signed duty value in the same convention the generator consumes: positive when dir=1, negative when dir=0. It sits between an input pin pair and the host register interface.

---
 rtl/pwmin_capture.sv | 183 ++++++++++++++++++
 tb/tb_pwmin_capture.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pwmin_capture.sv
// PWM/direction input capture: measures high time and period of a synchronized
// PWM line and reports a signed duty value whose sign follows the direction line.
module pwmin_capture #(
    parameter int unsigned TIMEOUT  = 10000000,
    parameter int unsigned CNT_BITS = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       pwm,
    input  logic                       dir,
    output logic signed [CNT_BITS-1:0] duty,
    output logic        [CNT_BITS-1:0] width,
    output logic        [CNT_BITS-1:0] period,
    output logic                       valid,
    output logic                       timeout,
    output logic                       level
);

    localparam int unsigned W = CNT_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    state_e         state_q,   state_d;
    logic           pwm_s1_q,  pwm_s1_d;
    logic           pwm_s2_q,  pwm_s2_d;
    logic           pwm_prv_q, pwm_prv_d;
    logic           dir_s1_q,  dir_s1_d;
    logic           dir_s2_q,  dir_s2_d;
    logic [W-1:0]   hi_cnt_q,  hi_cnt_d;
    logic [W-1:0]   per_cnt_q, per_cnt_d;
    logic [W-1:0]   width_l_q, width_l_d;
    logic           dir_l_q,   dir_l_d;
    logic [W-1:0]   duty_q,    duty_d;
    logic [W-1:0]   width_q,   width_d;
    logic [W-1:0]   period_q,  period_d;
    logic           valid_q,   valid_d;
    logic           timeout_q, timeout_d;

    logic           rise;
    logic           fall;
    logic           at_limit;

    // Next-state and output computation
    always_comb begin
        state_d   = state_q;
        hi_cnt_d  = hi_cnt_q;
        per_cnt_d = per_cnt_q;
        width_l_d = width_l_q;
        dir_l_d   = dir_l_q;
        duty_d    = duty_q;
        width_d   = width_q;
        period_d  = period_q;
        timeout_d = timeout_q;
        valid_d   = 1'b0;

        pwm_s1_d  = pwm;
        pwm_s2_d  = pwm_s1_q;
        pwm_prv_d = pwm_s2_q;
        dir_s1_d  = dir;
        dir_s2_d  = dir_s1_q;

        rise      = pwm_s2_q & ~pwm_prv_q;
        fall      = ~pwm_s2_q & pwm_prv_q;
        at_limit  = (per_cnt_q == W'(TIMEOUT));

        if (!enable) begin
            state_d   = ST_IDLE;
            hi_cnt_d  = '0;
            per_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    hi_cnt_d  = '0;
                    per_cnt_d = '0;
                    if (rise) begin
                        hi_cnt_d  = W'(1);
                        per_cnt_d = W'(1);
                        state_d   = ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (at_limit) begin
                        duty_d    = '0;
                        width_d   = '0;
                        period_d  = '0;
                        timeout_d = 1'b1;
                        valid_d   = 1'b1;
                        hi_cnt_d  = '0;
                        per_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        hi_cnt_d  = hi_cnt_q + W'(1);
                        per_cnt_d = per_cnt_q + W'(1);
                        if (fall) begin
                            width_l_d = hi_cnt_q;
                            dir_l_d   = dir_s2_q;
                            state_d   = ST_LOW;
                        end
                    end
                end
                ST_LOW: begin
                    // A rising edge on the limit cycle still completes the period
                    if (rise) begin
                        period_d  = per_cnt_q;
                        width_d   = width_l_q;
                        duty_d    = dir_l_q ? width_l_q : (W'(0) - width_l_q);
                        timeout_d = 1'b0;
                        valid_d   = 1'b1;
                        hi_cnt_d  = W'(1);
                        per_cnt_d = W'(1);
                        state_d   = ST_HIGH;
                    end else if (at_limit) begin
                        duty_d    = '0;
                        width_d   = '0;
                        period_d  = '0;
                        timeout_d = 1'b1;
                        valid_d   = 1'b1;
                        hi_cnt_d  = '0;
                        per_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        per_cnt_d = per_cnt_q + W'(1);
                    end
                end
                default: begin
                    hi_cnt_d  = '0;
                    per_cnt_d = '0;
                    state_d   = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pwm_s1_q  <= 1'b0;
            pwm_s2_q  <= 1'b0;
            pwm_prv_q <= 1'b0;
            dir_s1_q  <= 1'b0;
            dir_s2_q  <= 1'b0;
            hi_cnt_q  <= '0;
            per_cnt_q <= '0;
            width_l_q <= '0;
            dir_l_q   <= 1'b0;
            duty_q    <= '0;
            width_q   <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pwm_s1_q  <= pwm_s1_d;
            pwm_s2_q  <= pwm_s2_d;
            pwm_prv_q <= pwm_prv_d;
            dir_s1_q  <= dir_s1_d;
            dir_s2_q  <= dir_s2_d;
            hi_cnt_q  <= hi_cnt_d;
            per_cnt_q <= per_cnt_d;
            width_l_q <= width_l_d;
            dir_l_q   <= dir_l_d;
            duty_q    <= duty_d;
            width_q   <= width_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign duty    = $signed(duty_q);
    assign width   = width_q;
    assign period  = period_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;
    assign level   = pwm_s2_q;

endmodule

// File: tb/tb_pwmin_capture.sv
// Scoreboard bench for pwmin_capture: the driver predicts each report from pin
// edge times, a monitor pops and compares whenever valid is seen.
module tb_pwmin_capture;

    localparam int unsigned TO = 1000;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               enable = 1'b1;
    logic               pwm = 1'b0;
    logic               dir = 1'b1;
    logic signed [31:0] duty;
    logic        [31:0] width;
    logic        [31:0] period;
    logic               valid;
    logic               timeout;
    logic               level;

    pwmin_capture #(.TIMEOUT(TO), .CNT_BITS(32)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pwm(pwm), .dir(dir),
        .duty(duty), .width(width), .period(period), .valid(valid),
        .timeout(timeout), .level(level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] duty;
        logic [31:0] width;
        logic [31:0] period;
        logic        tmo;
        logic        lvl;
        logic        chk_lvl;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state (pin-side edge times)
    bit          armed = 1'b0;
    int          rise_c = 0;
    int          fall_c = 0;
    logic        fall_dir = 1'b0;
    logic [31:0] last_w = '0;
    logic [31:0] last_p = '0;
    logic [31:0] last_d = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: every valid strobe must match the oldest prediction
    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got valid=1 expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("valid_cycle", 32'(cyc), 32'(e.cyc));
                check("duty", 32'(duty), e.duty);
                check("width", width, e.width);
                check("period", period, e.period);
                check("timeout", 32'(timeout), 32'(e.tmo));
                if (e.chk_lvl) check("level", 32'(level), 32'(e.lvl));
            end
        end
    end

    // One clock of pin stimulus; predicts a report on every armed rising edge
    task automatic drive(input logic p, input logic d);
        exp_t e;
        @(negedge clk);
        if (p && !pwm) begin
            if (armed) begin
                e.width   = 32'(fall_c - rise_c);
                e.period  = 32'(cyc - rise_c);
                e.duty    = fall_dir ? e.width : (32'd0 - e.width);
                e.tmo     = 1'b0;
                e.lvl     = 1'b0;
                e.chk_lvl = 1'b0;
                e.cyc     = cyc + 3;
                sb.push_back(e);
                last_w = e.width;
                last_p = e.period;
                last_d = e.duty;
            end
            armed  = enable;
            rise_c = cyc;
        end else if (!p && pwm) begin
            fall_c   = cyc;
            fall_dir = d;
        end
        pwm = p;
        dir = d;
    endtask

    task automatic run_period(input int hi, input int per, input logic d);
        for (int i = 0; i < hi; i++) drive(1'b1, d);
        for (int i = 0; i < per - hi; i++) drive(1'b0, d);
    endtask

    // Hold the pin at p long enough for the dead-signal timeout to fire
    task automatic hold_timeout(input logic p, input int n);
        exp_t e;
        drive(p, dir);
        e.duty    = '0;
        e.width   = '0;
        e.period  = '0;
        e.tmo     = 1'b1;
        e.lvl     = p;
        e.chk_lvl = 1'b1;
        e.cyc     = rise_c + 3 + int'(TO);
        sb.push_back(e);
        for (int i = 1; i < n; i++) drive(p, dir);
        armed = 1'b0;
    endtask

    initial begin
        // Reset held with the pin toggling
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i % 3 == 0) pwm = ~pwm;
            check("rst_valid", 32'(valid), 32'd0);
            check("rst_level", 32'(level), 32'd0);
        end
        check("rst_duty", 32'(duty), 32'd0);
        check("rst_width", width, 32'd0);
        check("rst_period", period, 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        pwm = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_width", width, 32'd0);

        // 25/75 with dir=1, then dir=0
        for (int k = 0; k < 4; k++) run_period(25, 100, 1'b1);
        for (int k = 0; k < 4; k++) run_period(25, 100, 1'b0);

        // Extreme duty: 1/10 and 9/10
        for (int k = 0; k < 3; k++) run_period(1, 10, 1'b1);
        for (int k = 0; k < 3; k++) run_period(9, 10, 1'b1);

        // Stuck low after a valid period, then restart
        hold_timeout(1'b0, int'(TO) + 20);
        run_period(25, 100, 1'b1);
        check("timeout_sticky", 32'(timeout), 32'd1);
        for (int k = 0; k < 2; k++) run_period(25, 100, 1'b1);

        // Stuck high
        hold_timeout(1'b1, int'(TO) + 20);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1);

        // Enable dropped mid-LOW, raised 50 clocks later
        for (int k = 0; k < 2; k++) run_period(25, 100, 1'b1);
        for (int i = 0; i < 25; i++) drive(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1);
        @(negedge clk);
        enable = 1'b0;
        armed  = 1'b0;
        for (int i = 0; i < 50; i++) drive(1'b0, 1'b1);
        @(negedge clk);
        enable = 1'b1;
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1);
        check("en_hold_width", width, last_w);
        check("en_hold_period", period, last_p);
        check("en_hold_duty", 32'(duty), last_d);
        for (int k = 0; k < 3; k++) run_period(25, 100, 1'b1);

        // Drain any outstanding predictions with a bounded wait
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1);
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
